// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: FETCH -> DECODE -> EXEC -> (MEM) -> WB, plus TRAP/HALT.
// ALU codes: {alt, funct3}; slt/sltu and branch compares set bit 3.
module multicycle_ctrl #(
    parameter int MEM_MASK_WIDTH  = 4,
    parameter int ALU_FUNCT_WIDTH = 4,
    parameter bit EN_MDU          = 1'b1,
    parameter int MEM_TIMEOUT     = 255,
    parameter int CNT_WIDTH       = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       inst_req,
    input  logic                       inst_valid,
    input  logic [6:0]                 opcode,
    input  logic [2:0]                 funct3,
    input  logic [6:0]                 funct7,
    input  logic [11:0]                rs2_is_x0_imm,
    input  logic [1:0]                 addr_lo,
    input  logic                       br_taken,
    output logic [ALU_FUNCT_WIDTH-1:0] alu_funct,
    output logic                       alu_b_is_imm,
    output logic                       mdu_start,
    input  logic                       mdu_done,
    output logic                       lsu_req,
    output logic                       lsu_we,
    output logic [MEM_MASK_WIDTH-1:0]  mem_mask,
    input  logic                       lsu_ack,
    output logic                       gpr_w_en,
    output logic                       rd_is_mem,
    output logic                       rd_is_mdu,
    output logic                       pc_en,
    output logic [1:0]                 pc_sel,
    output logic                       trap_valid,
    output logic [3:0]                 trap_cause,
    output logic                       halt,
    output logic [CNT_WIDTH-1:0]       instret
);

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_SYS   = 7'b1110011;

    localparam logic [3:0] C_ILLEGAL = 4'd2;
    localparam logic [3:0] C_LD_MIS  = 4'd4;
    localparam logic [3:0] C_LD_FLT  = 4'd5;
    localparam logic [3:0] C_ST_MIS  = 4'd6;
    localparam logic [3:0] C_ST_FLT  = 4'd7;
    localparam logic [3:0] C_ECALL   = 4'd11;

    localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP,
        S_HALT
    } state_e;

    state_e               state_q, state_d;
    logic [6:0]           op_q, op_d;
    logic [2:0]           f3_q, f3_d;
    logic [6:0]           f7_q, f7_d;
    logic [11:0]          imm_q, imm_d;
    logic [1:0]           addr_q, addr_d;
    logic                 taken_q, taken_d;
    logic                 mdu_go_q, mdu_go_d;
    logic [15:0]          wait_q, wait_d;
    logic [3:0]           cause_q, cause_d;
    logic [CNT_WIDTH-1:0] instret_q, instret_d;

    logic is_lui, is_auipc, is_jal, is_jalr, is_br;
    logic is_ld, is_st, is_opi, is_op, is_sys;
    logic is_mdu, is_ecall, is_ebreak;
    logic bad_f3, legal_op, illegal;
    logic misalign;
    logic b_imm;
    logic [3:0] alu_fn;
    logic [MEM_MASK_WIDTH-1:0] mask;

    always_comb begin
        is_lui    = op_q == OP_LUI;
        is_auipc  = op_q == OP_AUIPC;
        is_jal    = op_q == OP_JAL;
        is_jalr   = op_q == OP_JALR;
        is_br     = op_q == OP_BR;
        is_ld     = op_q == OP_LD;
        is_st     = op_q == OP_ST;
        is_opi    = op_q == OP_IMM;
        is_op     = op_q == OP_REG;
        is_sys    = op_q == OP_SYS;
        is_mdu    = is_op && f7_q == 7'b0000001;
        is_ecall  = is_sys && f3_q == 3'b000 && imm_q == 12'd0;
        is_ebreak = is_sys && f3_q == 3'b000 && imm_q == 12'd1;
        legal_op  = is_lui | is_auipc | is_jal | is_jalr | is_br
                  | is_ld | is_st | is_opi | is_op | is_sys;
        bad_f3    = (is_br && f3_q[2:1] == 2'b01)
                  | (is_ld && (f3_q == 3'b011 || f3_q[2:1] == 2'b11))
                  | (is_st && f3_q >= 3'b011);
        illegal   = !legal_op | bad_f3 | (is_mdu & !EN_MDU)
                  | (is_sys & !is_ecall & !is_ebreak);
        misalign  = (f3_q[1:0] == 2'b01 && addr_q[0])
                  | (f3_q[1:0] == 2'b10 && addr_q != 2'b00);
        b_imm     = is_lui | is_auipc | is_jal | is_jalr
                  | is_ld | is_st | is_opi;
    end

    always_comb begin
        alu_fn = 4'b0000;
        unique case (1'b1)
            is_op && !is_mdu: alu_fn = {f7_q[5], f3_q};
            is_opi: alu_fn = {f3_q == 3'b101 && f7_q[5], f3_q};
            is_br: begin
                unique case (f3_q[2:1])
                    2'b10:   alu_fn = 4'b1010;
                    2'b11:   alu_fn = 4'b1011;
                    default: alu_fn = 4'b1000;
                endcase
            end
            default: alu_fn = 4'b0000;
        endcase
        // slt/sltu share the compare path with the branch unit
        if ((is_op && !is_mdu) || is_opi) begin
            if (f3_q[2:1] == 2'b01) begin
                alu_fn[3] = 1'b1;
            end
        end
    end

    always_comb begin
        unique case (f3_q[1:0])
            2'b00:   mask = MEM_MASK_WIDTH'(1'b1);
            2'b01:   mask = MEM_MASK_WIDTH'(2'b11);
            default: mask = '1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        f3_d      = f3_q;
        f7_d      = f7_q;
        imm_d     = imm_q;
        addr_d    = addr_q;
        taken_d   = taken_q;
        mdu_go_d  = mdu_go_q;
        wait_d    = wait_q;
        cause_d   = cause_q;
        instret_d = instret_q;
        unique case (state_q)
            S_FETCH: begin
                if (inst_valid) begin
                    op_d    = opcode;
                    f3_d    = funct3;
                    f7_d    = funct7;
                    imm_d   = rs2_is_x0_imm;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                mdu_go_d = 1'b0;
                if (illegal) begin
                    cause_d = C_ILLEGAL;
                    state_d = S_TRAP;
                end else if (is_ecall) begin
                    cause_d = C_ECALL;
                    state_d = S_TRAP;
                end else if (is_ebreak) begin
                    instret_d = instret_q + CNT_WIDTH'(1);
                    state_d   = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                taken_d = is_br & br_taken;
                if (is_ld || is_st) begin
                    addr_d  = addr_lo;
                    wait_d  = '0;
                    state_d = S_MEM;
                end else if (is_mdu) begin
                    mdu_go_d = 1'b1;
                    if (mdu_done) begin
                        state_d = S_WB;
                    end
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (misalign) begin
                    cause_d = is_st ? C_ST_MIS : C_LD_MIS;
                    state_d = S_TRAP;
                end else if (lsu_ack) begin
                    state_d = S_WB;
                end else if (wait_q == WAIT_LAST) begin
                    cause_d = is_st ? C_ST_FLT : C_LD_FLT;
                    state_d = S_TRAP;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            S_WB: begin
                instret_d = instret_q + CNT_WIDTH'(1);
                state_d   = S_FETCH;
            end
            S_TRAP: state_d = S_FETCH;
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            f3_q      <= '0;
            f7_q      <= '0;
            imm_q     <= '0;
            addr_q    <= '0;
            taken_q   <= 1'b0;
            mdu_go_q  <= 1'b0;
            wait_q    <= '0;
            cause_q   <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            f3_q      <= f3_d;
            f7_q      <= f7_d;
            imm_q     <= imm_d;
            addr_q    <= addr_d;
            taken_q   <= taken_d;
            mdu_go_q  <= mdu_go_d;
            wait_q    <= wait_d;
            cause_q   <= cause_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        inst_req     = 1'b0;
        alu_funct    = '0;
        alu_b_is_imm = 1'b0;
        mdu_start    = 1'b0;
        lsu_req      = 1'b0;
        lsu_we       = 1'b0;
        mem_mask     = '0;
        gpr_w_en     = 1'b0;
        rd_is_mem    = 1'b0;
        rd_is_mdu    = 1'b0;
        pc_en        = 1'b0;
        pc_sel       = 2'd0;
        trap_valid   = 1'b0;
        trap_cause   = 4'd0;
        halt         = 1'b0;
        instret      = instret_q;
        unique case (state_q)
            S_FETCH: inst_req = 1'b1;
            S_DECODE: ;
            S_EXEC: begin
                alu_funct    = ALU_FUNCT_WIDTH'(alu_fn);
                alu_b_is_imm = b_imm;
                mdu_start    = is_mdu & !mdu_go_q;
            end
            S_MEM: begin
                alu_funct    = ALU_FUNCT_WIDTH'(alu_fn);
                alu_b_is_imm = b_imm;
                if (!misalign) begin
                    lsu_req  = 1'b1;
                    lsu_we   = is_st;
                    mem_mask = mask;
                end
            end
            S_WB: begin
                gpr_w_en  = !(is_br || is_st);
                rd_is_mem = is_ld;
                rd_is_mdu = is_mdu;
                pc_en     = 1'b1;
                if (is_jal || (is_br && taken_q)) begin
                    pc_sel = 2'd1;
                end else if (is_jalr) begin
                    pc_sel = 2'd2;
                end
            end
            S_TRAP: begin
                trap_valid = 1'b1;
                trap_cause = cause_q;
                pc_en      = 1'b1;
                pc_sel     = 2'd3;
            end
            S_HALT: halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: two instances, M-extension on (short
// memory timeout) and M-extension off.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst0 = 1'b1;
    logic        inst_valid = 1'b0;
    logic        inst_valid0 = 1'b0;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic [11:0] imm = '0;
    logic [1:0]  addr_lo = '0;
    logic        br_taken = 1'b0;
    logic        mdu_done = 1'b0;
    logic        lsu_ack = 1'b0;

    logic        inst_req, alu_b_is_imm, mdu_start, lsu_req, lsu_we;
    logic        gpr_w_en, rd_is_mem, rd_is_mdu, pc_en, trap_valid, halt;
    logic [3:0]  alu_funct, mem_mask, trap_cause;
    logic [1:0]  pc_sel;
    logic [63:0] instret;

    logic        inst_req0, alu_b_is_imm0, mdu_start0, lsu_req0, lsu_we0;
    logic        gpr_w_en0, rd_is_mem0, rd_is_mdu0, pc_en0, trap_valid0, halt0;
    logic [3:0]  alu_funct0, mem_mask0, trap_cause0;
    logic [1:0]  pc_sel0;
    logic [63:0] instret0;

    int checks = 0;
    int errors = 0;
    int starts;
    int req_cycles;

    always #5 clk = ~clk;

    multicycle_ctrl #(
        .EN_MDU(1'b1),
        .MEM_TIMEOUT(4)
    ) u_dut (
        .clk(clk), .rst(rst), .inst_req(inst_req), .inst_valid(inst_valid),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rs2_is_x0_imm(imm), .addr_lo(addr_lo), .br_taken(br_taken),
        .alu_funct(alu_funct), .alu_b_is_imm(alu_b_is_imm),
        .mdu_start(mdu_start), .mdu_done(mdu_done),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .mem_mask(mem_mask),
        .lsu_ack(lsu_ack), .gpr_w_en(gpr_w_en), .rd_is_mem(rd_is_mem),
        .rd_is_mdu(rd_is_mdu), .pc_en(pc_en), .pc_sel(pc_sel),
        .trap_valid(trap_valid), .trap_cause(trap_cause), .halt(halt),
        .instret(instret)
    );

    multicycle_ctrl #(
        .EN_MDU(1'b0),
        .MEM_TIMEOUT(255)
    ) u_dut0 (
        .clk(clk), .rst(rst0), .inst_req(inst_req0), .inst_valid(inst_valid0),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rs2_is_x0_imm(imm), .addr_lo(addr_lo), .br_taken(br_taken),
        .alu_funct(alu_funct0), .alu_b_is_imm(alu_b_is_imm0),
        .mdu_start(mdu_start0), .mdu_done(mdu_done),
        .lsu_req(lsu_req0), .lsu_we(lsu_we0), .mem_mask(mem_mask0),
        .lsu_ack(lsu_ack), .gpr_w_en(gpr_w_en0), .rd_is_mem(rd_is_mem0),
        .rd_is_mdu(rd_is_mdu0), .pc_en(pc_en0), .pc_sel(pc_sel0),
        .trap_valid(trap_valid0), .trap_cause(trap_cause0), .halt(halt0),
        .instret(instret0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present an instruction in FETCH and step into DECODE.
    task automatic fetch(input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [11:0] im);
        opcode     = op;
        funct3     = f3;
        funct7     = f7;
        imm        = im;
        inst_valid = 1'b1;
        tick();
        inst_valid = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_inst_req", 64'(inst_req), 64'd1);
        chk("rst_instret", instret, 64'd0);
        chk("rst_halt", 64'(halt), 64'd0);
        chk("rst_strobes", 64'({gpr_w_en, pc_en, trap_valid, lsu_req}), 64'd0);
        rst = 1'b0;

        // addi
        fetch(7'b0010011, 3'b000, 7'd0, 12'd5);
        chk("addi_dec_req", 64'(inst_req), 64'd0);
        tick();
        chk("addi_funct", 64'(alu_funct), 64'd0);
        chk("addi_bimm", 64'(alu_b_is_imm), 64'd1);
        chk("addi_exec_wen", 64'(gpr_w_en), 64'd0);
        tick();
        chk("addi_wb_wen", 64'(gpr_w_en), 64'd1);
        chk("addi_wb_pcen", 64'(pc_en), 64'd1);
        chk("addi_wb_pcsel", 64'(pc_sel), 64'd0);
        tick();
        chk("addi_instret", instret, 64'd1);
        chk("addi_wen_off", 64'(gpr_w_en), 64'd0);

        // lw, ack on the 4th request cycle (also the timeout boundary)
        addr_lo = 2'b00;
        fetch(7'b0000011, 3'b010, 7'd0, 12'd0);
        tick();
        tick();
        req_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            req_cycles += int'(lsu_req);
            tick();
        end
        req_cycles += int'(lsu_req);
        chk("lw_mask", 64'(mem_mask), 64'hf);
        chk("lw_we", 64'(lsu_we), 64'd0);
        lsu_ack = 1'b1;
        tick();
        lsu_ack = 1'b0;
        chk("lw_req_cycles", 64'(req_cycles), 64'd4);
        chk("lw_wb_wen", 64'(gpr_w_en), 64'd1);
        chk("lw_wb_mem", 64'(rd_is_mem), 64'd1);
        chk("lw_wb_req", 64'(lsu_req), 64'd0);
        tick();
        chk("lw_instret", instret, 64'd2);

        // sh misaligned
        addr_lo = 2'b01;
        fetch(7'b0100011, 3'b001, 7'd0, 12'd0);
        tick();
        tick();
        chk("sh_no_req", 64'(lsu_req), 64'd0);
        tick();
        chk("sh_trap", 64'(trap_valid), 64'd1);
        chk("sh_cause", 64'(trap_cause), 64'd6);
        chk("sh_pcsel", 64'(pc_sel), 64'd3);
        chk("sh_pcen", 64'(pc_en), 64'd1);
        tick();
        chk("sh_instret", instret, 64'd2);
        chk("sh_trap_off", 64'(trap_valid), 64'd0);

        // lw timeout, late ack ignored
        addr_lo = 2'b00;
        fetch(7'b0000011, 3'b010, 7'd0, 12'd0);
        tick();
        tick();
        req_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            req_cycles += int'(lsu_req);
            tick();
        end
        chk("to_req_cycles", 64'(req_cycles), 64'd4);
        chk("to_trap", 64'(trap_valid), 64'd1);
        chk("to_cause", 64'(trap_cause), 64'd5);
        lsu_ack = 1'b1;
        tick();
        lsu_ack = 1'b0;
        chk("to_fetch", 64'(inst_req), 64'd1);
        chk("to_req_off", 64'(lsu_req), 64'd0);
        chk("to_instret", instret, 64'd2);
        chk("to_no_wb", 64'(gpr_w_en), 64'd0);

        // mul on both instances
        rst0 = 1'b0;
        inst_valid0 = 1'b1;
        fetch(7'b0110011, 3'b000, 7'b0000001, 12'd0);
        inst_valid0 = 1'b0;
        tick();
        chk("mdu_off_trap", 64'(trap_valid0), 64'd1);
        chk("mdu_off_cause", 64'(trap_cause0), 64'd2);
        starts = 0;
        for (int i = 0; i < 10; i++) begin
            starts += int'(mdu_start);
            if (i == 9) mdu_done = 1'b1;
            tick();
        end
        mdu_done = 1'b0;
        chk("mul_starts", 64'(starts), 64'd1);
        chk("mul_wb_mdu", 64'(rd_is_mdu), 64'd1);
        chk("mul_wb_wen", 64'(gpr_w_en), 64'd1);
        tick();
        chk("mul_instret", instret, 64'd3);
        chk("mdu_off_instret", instret0, 64'd0);

        // beq taken
        fetch(7'b1100011, 3'b000, 7'd0, 12'd0);
        tick();
        chk("beq_funct", 64'(alu_funct), 64'h8);
        chk("beq_bimm", 64'(alu_b_is_imm), 64'd0);
        br_taken = 1'b1;
        tick();
        br_taken = 1'b0;
        chk("beq_pcsel", 64'(pc_sel), 64'd1);
        chk("beq_wen", 64'(gpr_w_en), 64'd0);
        tick();
        chk("beq_instret", instret, 64'd4);

        // srai, slti, jalr
        fetch(7'b0010011, 3'b101, 7'b0100000, 12'd0);
        tick();
        chk("srai_funct", 64'(alu_funct), 64'hd);
        tick();
        tick();
        fetch(7'b0010011, 3'b010, 7'd0, 12'd0);
        tick();
        chk("slti_funct", 64'(alu_funct), 64'ha);
        tick();
        tick();
        fetch(7'b1100111, 3'b000, 7'd0, 12'd0);
        tick();
        tick();
        chk("jalr_pcsel", 64'(pc_sel), 64'd2);
        chk("jalr_wen", 64'(gpr_w_en), 64'd1);
        tick();
        chk("jalr_instret", instret, 64'd7);

        // illegal opcode, bad load funct3, ecall
        fetch(7'b0000000, 3'b000, 7'd0, 12'd0);
        tick();
        chk("ill_cause", 64'(trap_cause), 64'd2);
        tick();
        fetch(7'b0000011, 3'b011, 7'd0, 12'd0);
        tick();
        chk("ldf3_cause", 64'(trap_cause), 64'd2);
        tick();
        fetch(7'b1110011, 3'b000, 7'd0, 12'd0);
        tick();
        chk("ecall_cause", 64'(trap_cause), 64'd11);
        tick();
        chk("ecall_instret", instret, 64'd7);

        // ebreak halts until reset
        fetch(7'b1110011, 3'b000, 7'd0, 12'd1);
        tick();
        chk("ebrk_halt", 64'(halt), 64'd1);
        chk("ebrk_instret", instret, 64'd8);
        inst_valid = 1'b1;
        tick();
        tick();
        tick();
        inst_valid = 1'b0;
        chk("ebrk_stuck", 64'(halt), 64'd1);
        chk("ebrk_no_req", 64'(inst_req), 64'd0);
        chk("ebrk_instret2", instret, 64'd8);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_halt", 64'(halt), 64'd0);
        chk("rst2_instret", instret, 64'd0);
        chk("rst2_req", 64'(inst_req), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
